// File: rtl/pga_cmd_sequencer.sv
// pga_cmd_sequencer: Wishbone command front end for the PGA serial controller.
// Software queues PGA commands in a small FIFO. They are issued one at a time
// to pga_control as single-cycle strobes, and each one waits for op_complete.
// Optional feature macro: PGA_CMD_TIMEOUT_EN adds a WAIT-state watchdog.
module pga_cmd_sequencer #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        clk25,
    input  logic        wb_rst,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [1:0]  wb_adr_i,
    input  logic [15:0] wb_dat_i,
    output logic [15:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        set_vos,
    output logic        set_gain,
    output logic        set_measure,
    output logic [4:0]  offset,
    output logic [3:0]  gain,
    input  logic        op_complete,
    output logic        busy,
    output logic        irq
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [10:0]   mem_q [FIFO_DEPTH];
    logic [10:0]   mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [1:0]    cur_op_q, cur_op_d;
    logic [4:0]    offset_q, offset_d;
    logic [3:0]    gain_q, gain_d;
    logic [2:0]    strobe_q, strobe_d;
    logic [15:0]   done_q, done_d;
    logic          overflow_q, overflow_d;
    logic          timeout_q, timeout_d;
    logic          bad_op_q, bad_op_d;
    logic          ack_q, ack_d;
    logic [15:0]   dat_q, dat_d;
    logic          busy_q, busy_d;
    logic          irq_q, irq_d;

    logic          req_s, wr_s, cmd_wr_s, stat_wr_s, done_wr_s;
    logic          full_s, push_s, pop_s, ovf_set_s, bad_set_s;
    logic          done_inc_s, tmo_set_s;
    logic [10:0]   entry_s;
    logic [15:0]   status_s;
    logic [4:0]    unused_dat_s;

    // A new request is accepted only while no ack is outstanding; write side
    // effects land on the edge where the master samples the ack.
    assign req_s     = wb_cyc_i & wb_stb_i & ~ack_q;
    assign wr_s      = ack_q & wb_cyc_i & wb_stb_i & wb_we_i;
    assign cmd_wr_s  = wr_s & (wb_adr_i == 2'd0);
    assign stat_wr_s = wr_s & (wb_adr_i == 2'd1);
    assign done_wr_s = wr_s & (wb_adr_i == 2'd2);
    assign full_s    = (count_q == DEPTH_C);
    assign bad_set_s = cmd_wr_s & (wb_dat_i[1:0] == 2'd3);
    assign push_s    = cmd_wr_s & (wb_dat_i[1:0] != 2'd3) & ~full_s;
    assign ovf_set_s = cmd_wr_s & (wb_dat_i[1:0] != 2'd3) & full_s;
    assign entry_s   = {wb_dat_i[1:0], wb_dat_i[6:2], wb_dat_i[10:7]};
    assign unused_dat_s = wb_dat_i[15:11];

`ifdef PGA_CMD_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] tmo_cnt_q, tmo_cnt_d;

    // Watchdog counts WAIT cycles; it is zero everywhere else so every WAIT starts fresh.
    always_comb begin
        if (state_q == ST_WAIT) begin
            tmo_cnt_d = tmo_cnt_q + 16'd1;
        end else begin
            tmo_cnt_d = 16'd0;
        end
    end

    // Watchdog counter register.
    always_ff @(posedge clk25) begin
        if (wb_rst) begin
            tmo_cnt_q <= 16'd0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    logic [15:0] unused_tmo_s;
    assign unused_tmo_s = 16'(TIMEOUT_CYCLES);
`endif

    // STATUS register image.
    always_comb begin
        status_s       = 16'd0;
        status_s[0]    = busy_q;
        status_s[1]    = (count_q == {CW{1'b0}});
        status_s[2]    = full_s;
        status_s[3]    = overflow_q;
        status_s[4]    = timeout_q;
        status_s[5]    = bad_op_q;
        status_s[11:8] = 4'(count_q);
    end

    // Wishbone ack and read data; data is non-zero only while ack is high.
    always_comb begin
        ack_d = req_s;
        dat_d = 16'd0;
        if (req_s && !wb_we_i) begin
            case (wb_adr_i)
                2'd1:    dat_d = status_s;
                2'd2:    dat_d = done_q;
                default: dat_d = 16'd0;
            endcase
        end else begin
            dat_d = 16'd0;
        end
    end

    // Sequencer next state: pop in IDLE, strobe in ISSUE, wait for completion.
    always_comb begin
        state_d    = state_q;
        pop_s      = 1'b0;
        cur_op_d   = cur_op_q;
        offset_d   = offset_q;
        gain_d     = gain_q;
        strobe_d   = 3'b000;
        done_inc_s = 1'b0;
        tmo_set_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (count_q != {CW{1'b0}}) begin
                    pop_s    = 1'b1;
                    cur_op_d = mem_q[rd_ptr_q][10:9];
                    offset_d = mem_q[rd_ptr_q][8:4];
                    gain_d   = mem_q[rd_ptr_q][3:0];
                    state_d  = ST_ISSUE;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                case (cur_op_q)
                    2'd0:    strobe_d = 3'b001;
                    2'd1:    strobe_d = 3'b010;
                    2'd2:    strobe_d = 3'b100;
                    default: strobe_d = 3'b000;
                endcase
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (op_complete) begin
                    done_inc_s = 1'b1;
                    state_d    = ST_GAP;
`ifdef PGA_CMD_TIMEOUT_EN
                end else if (tmo_cnt_q == TMO_LAST) begin
                    tmo_set_s  = 1'b1;
                    state_d    = ST_GAP;
`endif
                end else begin
                    state_d    = ST_WAIT;
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FIFO storage, pointers and occupancy; a simultaneous push and pop keep the count.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_s) begin
            mem_d[wr_ptr_q] = entry_s;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end else begin
            wr_ptr_d        = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Sticky error bits (a set wins over a same-cycle W1C), DONE counter, busy and irq.
    always_comb begin
        overflow_d = (overflow_q & ~(stat_wr_s & wb_dat_i[3])) | ovf_set_s;
        timeout_d  = (timeout_q  & ~(stat_wr_s & wb_dat_i[4])) | tmo_set_s;
        bad_op_d   = (bad_op_q   & ~(stat_wr_s & wb_dat_i[5])) | bad_set_s;
        if (done_wr_s) begin
            done_d = 16'd0;
        end else if (done_inc_s) begin
            done_d = done_q + 16'd1;
        end else begin
            done_d = done_q;
        end
        busy_d = (state_d != ST_IDLE) | (count_d != {CW{1'b0}});
        irq_d  = overflow_q | timeout_q | bad_op_q;
    end

    // FSM state register.
    always_ff @(posedge clk25) begin
        if (wb_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath, FIFO and output registers.
    always_ff @(posedge clk25) begin
        if (wb_rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 11'd0;
            end
            wr_ptr_q   <= {AW{1'b0}};
            rd_ptr_q   <= {AW{1'b0}};
            count_q    <= {CW{1'b0}};
            cur_op_q   <= 2'd0;
            offset_q   <= 5'd0;
            gain_q     <= 4'd0;
            strobe_q   <= 3'b000;
            done_q     <= 16'd0;
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
            bad_op_q   <= 1'b0;
            ack_q      <= 1'b0;
            dat_q      <= 16'd0;
            busy_q     <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            cur_op_q   <= cur_op_d;
            offset_q   <= offset_d;
            gain_q     <= gain_d;
            strobe_q   <= strobe_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
            timeout_q  <= timeout_d;
            bad_op_q   <= bad_op_d;
            ack_q      <= ack_d;
            dat_q      <= dat_d;
            busy_q     <= busy_d;
            irq_q      <= irq_d;
        end
    end

    assign wb_ack_o    = ack_q;
    assign wb_dat_o    = dat_q;
    assign set_vos     = strobe_q[0];
    assign set_gain    = strobe_q[1];
    assign set_measure = strobe_q[2];
    assign offset      = offset_q;
    assign gain        = gain_q;
    assign busy        = busy_q;
    assign irq         = irq_q;

endmodule
